switch_conditioner: RTL and testbench
=====================================

Name: switch_conditioner

Overview:
Conditions the raw slide-switch bank before it reaches the CPU operand/reset inputs and the input-digit display decoders.
- Each bit gets a two-flop synchroniser, then a per-bit stability (debounce) counter.
- Outputs a clean, glitch-free level plus single-cycle rise/fall strobes.
- Runs on the slow scan clock SEGclk, so debounce windows are measured in SEGclk ticks.

Parameters:
- WIDTH, 9: number of switch bits (bit 8 = CPU reset switch, bits 7:0 = operand).
- STABLE_TICKS, 4: consecutive SEGclk edges a synchronised bit must differ from its clean value before the clean value updates. Legal range 1..2^CNT_W.
- CNT_W, 3: width of each per-bit stability counter.

Ports:
- SEGclk, input, 1: scan-rate clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset sampled on SEGclk.
- sw_raw, input, WIDTH: asynchronous raw switch pins.
- sw_clean, output, WIDTH: debounced switch levels (registered).
- sw_rise, output, WIDTH: one-cycle pulse per bit when sw_clean goes 0->1 (registered).
- sw_fall, output, WIDTH: one-cycle pulse per bit when sw_clean goes 1->0 (registered).
- any_change, output, 1: registered OR of all sw_rise and sw_fall bits, asserted in the same cycle as them.

Behaviour:
- Reset, synchronous on SEGclk with reset=1: sync1, sync2, all counters, sw_clean, sw_rise, sw_fall and any_change are set to 0. Reset overrides everything, including mid-count. After reset deasserts, a switch held high is treated as a fresh 0->1 change and produces a sw_rise pulse.
- Synchroniser: sync1 <= sw_raw; sync2 <= sync1. Only sync2 (s) feeds the debounce logic. No raw bit reaches any output combinationally.
- Per bit i, on every SEGclk edge when reset=0:
  - s[i]==sw_clean[i]: cnt[i] <= 0; no pulse.
  - s[i]!=sw_clean[i] and cnt[i]<STABLE_TICKS-1: cnt[i] <= cnt[i]+1; no pulse.
  - s[i]!=sw_clean[i] and cnt[i]==STABLE_TICKS-1: sw_clean[i] <= s[i]; cnt[i] <= 0; sw_rise[i] <= s[i]; sw_fall[i] <= ~s[i].
- sw_rise and sw_fall default to 0 each cycle, so each pulse is exactly one SEGclk cycle wide. They are asserted in the same cycle sw_clean changes.
- Latency: a raw change set up before edge 0 appears on sw_clean after edge 1+STABLE_TICKS, i.e. 2+STABLE_TICKS edges in total (6 at the default).
- Glitch rejection: any excursion of s lasting fewer than STABLE_TICKS consecutive edges never reaches sw_clean. The counter clears the moment s returns to the clean value, so there is no accumulation across separate glitches.
- STABLE_TICKS=1: the clean value updates on the first edge where s differs (latency 3 edges).
- Bits are fully independent. Simultaneous changes on several bits each follow their own counter; any_change asserts once per cycle regardless of how many bits pulse.
- Counter never exceeds STABLE_TICKS-1, so no wrap-around is possible.
- sw_rise[i] and sw_fall[i] are never both 1 in the same cycle.

Test Plan:
- Reset with sw_raw=9'h1FF held, then release reset -> sw_clean=0 during reset; sw_clean=9'h1FF after 6 edges; sw_rise=9'h1FF for exactly 1 cycle; any_change=1 for that cycle.
- From a clean value of 0, raise sw_raw[3] for 3 edges, then drop it -> sw_clean stays 9'h000; no rise/fall/any_change pulse.
- Raise sw_raw[3] and hold -> sw_clean[3]=1 exactly 6 edges after the change. Then lower it and hold -> sw_fall[3] pulses once 6 edges later.
- Raise sw_raw[0] and sw_raw[7] one edge apart -> independent updates 1 edge apart, two separate single-cycle any_change pulses, all other bits unaffected.
- With sw_raw[5] mid-count (cnt=2), assert reset for 1 cycle while sw_raw[5] stays high -> counter cleared and sw_clean[5]=0; after release, full 6-edge latency again before sw_clean[5]=1.
- Rebuild with STABLE_TICKS=1 and toggle sw_raw[8] -> sw_clean[8] follows 3 edges after each change; a 1-edge glitch does propagate.

Source files
------------

// File: rtl/switch_conditioner.sv
// Slide-switch conditioner: two-flop synchroniser plus per-bit debounce.
// Produces clean levels and one-cycle rise/fall strobes on SEGclk.
module switch_conditioner #(
    parameter int WIDTH        = 9,
    parameter int STABLE_TICKS = 4,
    parameter int CNT_W        = 3
) (
    input  logic             SEGclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             any_change
);

    // Terminal count: the edge on which a persistent difference is accepted.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];

    logic [WIDTH-1:0] clean_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    // Two-flop synchroniser for the asynchronous switch pins.
    always_ff @(posedge SEGclk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Per-bit stability counter; any return to the clean level clears it.
    always_comb begin
        clean_nxt = sw_clean;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (sync2[i] == sw_clean[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == LAST) begin
                cnt_nxt[i]   = '0;
                clean_nxt[i] = sync2[i];
                rise_nxt[i]  = sync2[i];
                fall_nxt[i]  = ~sync2[i];
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Register counters, clean levels and strobes together.
    always_ff @(posedge SEGclk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            sw_clean   <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            any_change <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            sw_clean   <= clean_nxt;
            sw_rise    <= rise_nxt;
            sw_fall    <= fall_nxt;
            any_change <= |(rise_nxt | fall_nxt);
        end
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench: stimulus queues hand-computed expectations per cycle,
// monitors compare the default build and a STABLE_TICKS=1 build.
module tb_switch_conditioner;

    logic       SEGclk = 1'b0;
    logic       reset;
    logic [8:0] raw0, raw1;
    logic [8:0] clean0, rise0, fall0;
    logic [8:0] clean1, rise1, fall1;
    logic       any0, any1;

    int cyc    = 0;
    int total  = 0;
    int passed = 0;

    typedef struct {
        int         cyc;
        logic [8:0] clean;
        logic [8:0] rise;
        logic [8:0] fall;
        logic       any;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    switch_conditioner u_dut0 (
        .SEGclk     (SEGclk),
        .reset      (reset),
        .sw_raw     (raw0),
        .sw_clean   (clean0),
        .sw_rise    (rise0),
        .sw_fall    (fall0),
        .any_change (any0)
    );

    switch_conditioner #(
        .WIDTH        (9),
        .STABLE_TICKS (1),
        .CNT_W        (3)
    ) u_dut1 (
        .SEGclk     (SEGclk),
        .reset      (reset),
        .sw_raw     (raw1),
        .sw_clean   (clean1),
        .sw_rise    (rise1),
        .sw_fall    (fall1),
        .any_change (any1)
    );

    always #5 SEGclk = ~SEGclk;

    always @(posedge SEGclk) cyc <= cyc + 1;

    task automatic chk(string name, logic [8:0] got, logic [8:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    endtask

    task automatic push0(int c, logic [8:0] cl, logic [8:0] r, logic [8:0] f);
        exp_t e;
        e.cyc = c; e.clean = cl; e.rise = r; e.fall = f;
        e.any = ((r | f) != 9'h0);
        q0.push_back(e);
    endtask

    task automatic push1(int c, logic [8:0] cl, logic [8:0] r, logic [8:0] f);
        exp_t e;
        e.cyc = c; e.clean = cl; e.rise = r; e.fall = f;
        e.any = ((r | f) != 9'h0);
        q1.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(negedge SEGclk);
    endtask

    // Monitor for the default build
    always @(negedge SEGclk) begin
        exp_t e;
        while (q0.size() > 0 && q0[0].cyc < cyc) begin
            e = q0.pop_front();
            chk("d0 missed", 9'(e.cyc), 9'(cyc));
        end
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            e = q0.pop_front();
            chk("d0 clean", clean0, e.clean);
            chk("d0 rise", rise0, e.rise);
            chk("d0 fall", fall0, e.fall);
            chk("d0 any", {8'h0, any0}, {8'h0, e.any});
        end else begin
            chk("d0 idle pulse", rise0 | fall0, 9'h0);
            chk("d0 idle any", {8'h0, any0}, 9'h0);
        end
    end

    // Monitor for the STABLE_TICKS=1 build
    always @(negedge SEGclk) begin
        exp_t e;
        while (q1.size() > 0 && q1[0].cyc < cyc) begin
            e = q1.pop_front();
            chk("d1 missed", 9'(e.cyc), 9'(cyc));
        end
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            e = q1.pop_front();
            chk("d1 clean", clean1, e.clean);
            chk("d1 rise", rise1, e.rise);
            chk("d1 fall", fall1, e.fall);
            chk("d1 any", {8'h0, any1}, {8'h0, e.any});
        end else begin
            chk("d1 idle pulse", rise1 | fall1, 9'h0);
            chk("d1 idle any", {8'h0, any1}, 9'h0);
        end
    end

    initial begin
        int c;
        reset = 1'b1;
        raw0  = 9'h1FF;
        raw1  = 9'h000;
        step(1);
        push0(cyc + 2, 9'h000, 9'h000, 9'h000);
        push1(cyc + 2, 9'h000, 9'h000, 9'h000);
        step(3);

        // release reset with all switches high: fresh rise after 6 edges
        reset = 1'b0;
        c = cyc;
        push0(c + 5, 9'h000, 9'h000, 9'h000);
        push0(c + 6, 9'h1FF, 9'h1FF, 9'h000);
        push0(c + 7, 9'h1FF, 9'h000, 9'h000);
        step(10);

        // drop everything: fall on all bits
        raw0 = 9'h000;
        c = cyc;
        push0(c + 6, 9'h000, 9'h000, 9'h1FF);
        push0(c + 7, 9'h000, 9'h000, 9'h000);
        step(10);

        // 3-edge glitch on bit 3 is rejected
        raw0 = 9'h008;
        c = cyc;
        push0(c + 6, 9'h000, 9'h000, 9'h000);
        push0(c + 8, 9'h000, 9'h000, 9'h000);
        step(3);
        raw0 = 9'h000;
        step(1);
        raw0 = 9'h008;
        step(3);
        raw0 = 9'h000;
        step(10);

        // held bit 3: rise then fall, 6 edges each
        raw0 = 9'h008;
        c = cyc;
        push0(c + 5, 9'h000, 9'h000, 9'h000);
        push0(c + 6, 9'h008, 9'h008, 9'h000);
        push0(c + 7, 9'h008, 9'h000, 9'h000);
        step(10);
        raw0 = 9'h000;
        c = cyc;
        push0(c + 5, 9'h008, 9'h000, 9'h000);
        push0(c + 6, 9'h000, 9'h000, 9'h008);
        push0(c + 7, 9'h000, 9'h000, 9'h000);
        step(10);

        // bits 0 and 7 one edge apart
        raw0 = 9'h001;
        c = cyc;
        push0(c + 6, 9'h001, 9'h001, 9'h000);
        push0(c + 7, 9'h081, 9'h080, 9'h000);
        push0(c + 8, 9'h081, 9'h000, 9'h000);
        step(1);
        raw0 = 9'h081;
        step(10);
        raw0 = 9'h000;
        c = cyc;
        push0(c + 6, 9'h000, 9'h000, 9'h081);
        push0(c + 7, 9'h000, 9'h000, 9'h000);
        step(10);

        // reset while bit 5 is mid-count restarts the full latency
        raw0 = 9'h020;
        c = cyc;
        step(4);
        push0(cyc + 1, 9'h000, 9'h000, 9'h000);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        c = cyc;
        push0(c + 5, 9'h000, 9'h000, 9'h000);
        push0(c + 6, 9'h020, 9'h020, 9'h000);
        push0(c + 7, 9'h020, 9'h000, 9'h000);
        step(10);
        raw0 = 9'h000;
        c = cyc;
        push0(c + 6, 9'h000, 9'h000, 9'h020);
        step(10);

        // STABLE_TICKS=1: 3-edge latency, single-edge glitch propagates
        raw1 = 9'h100;
        c = cyc;
        push1(c + 2, 9'h000, 9'h000, 9'h000);
        push1(c + 3, 9'h100, 9'h100, 9'h000);
        push1(c + 4, 9'h100, 9'h000, 9'h000);
        step(6);
        raw1 = 9'h000;
        c = cyc;
        push1(c + 2, 9'h100, 9'h000, 9'h000);
        push1(c + 3, 9'h000, 9'h000, 9'h100);
        step(6);
        raw1 = 9'h100;
        c = cyc;
        push1(c + 3, 9'h100, 9'h100, 9'h000);
        push1(c + 4, 9'h000, 9'h000, 9'h100);
        push1(c + 5, 9'h000, 9'h000, 9'h000);
        step(1);
        raw1 = 9'h000;
        step(8);

        chk("q0 leftover", 9'(q0.size()), 9'h0);
        chk("q1 leftover", 9'(q1.size()), 9'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
